// File: rtl/decode_pkg.sv
// Shared opcode/funct constants and FSM state type for the decode stage.
package decode_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BC      = 6'b110010;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;

  localparam logic [5:0] FN_JR  = 6'b001001;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  function automatic logic is_store(input logic [5:0] op);
    return op[5:3] == 3'b101;
  endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Busy mask for registers awaiting write-back; a same-cycle write-back
// counts as ready because the register file is write-first.
module decode_scoreboard
  import decode_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       set_en_i,
  input  logic [4:0] set_reg_i,
  input  logic       clr_en_i,
  input  logic [4:0] clr_reg_i,
  input  logic [4:0] qa_addr_i,
  input  logic [4:0] qb_addr_i,
  output logic       qa_ready_o,
  output logic       qb_ready_o
);

  logic [31:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_reg_i] = 1'b0;
    // set applied last so an issuing writer wins over an old write-back
    if (set_en_i) busy_d[set_reg_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign qa_ready_o = (qa_addr_i == 5'd0) || !busy_q[qa_addr_i] ||
                      (clr_en_i && (clr_reg_i == qa_addr_i));
  assign qb_ready_o = (qb_addr_i == 5'd0) || !busy_q[qb_addr_i] ||
                      (clr_en_i && (clr_reg_i == qb_addr_i));

endmodule

// File: rtl/decode_stage.sv
// Decode stage: field split, immediate extension, hazard hold and
// registered decode bundle for execute.
//
//   state | meaning
//   IDLE  | waiting for fetch; incoming instruction decoded directly
//   HOLD  | instruction parked in hold register until its sources are ready
module decode_stage
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic [31:0] pc,
  input  logic [31:0] command,
  input  logic        flush,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        wb_en,
  input  logic [4:0]  wb_reg,
  output logic        stall,
  output logic        done,
  output logic [31:0] d_pc,
  output logic [31:0] d_command,
  output logic [31:0] d_imm,
  output logic [31:0] d_rs_val,
  output logic [31:0] d_rt_val,
  output logic [4:0]  d_dst,
  output logic        d_wen
);

  state_e      state_q, state_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_cmd_q, hold_cmd_d;
  logic        done_q;
  logic [31:0] d_pc_q, d_cmd_q, d_imm_q, d_rs_q, d_rt_q;
  logic [4:0]  d_dst_q;
  logic        d_wen_q;

  logic [31:0] cur_pc, cur_cmd;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic        has_dst, wen, need_rs, need_rt, is_shift;
  logic [4:0]  dst;
  logic [31:0] imm;
  logic        rs_rdy, rt_rdy, ready, issue;

  assign cur_pc  = (state_q == HOLD) ? hold_pc_q  : pc;
  assign cur_cmd = (state_q == HOLD) ? hold_cmd_q : command;

  assign op    = cur_cmd[31:26];
  assign rs    = cur_cmd[25:21];
  assign rt    = cur_cmd[20:16];
  assign rd    = cur_cmd[15:11];
  assign funct = cur_cmd[5:0];
  assign imm16 = cur_cmd[15:0];

  assign is_shift = (op == OP_SPECIAL) &&
                    (funct == FN_SLL || funct == FN_SRL || funct == FN_SRA);

  always_comb begin
    has_dst = 1'b1;
    dst     = rt;
    if (op == OP_SPECIAL) begin
      dst     = rd;
      has_dst = !((funct == FN_JR) && (rd == 5'd0));
    end else if (op == OP_JAL) begin
      dst = REG_RA;
    end else if (op == OP_J || op == OP_BC || op == OP_BEQ || op == OP_BNE ||
                 is_store(op)) begin
      has_dst = 1'b0;
      dst     = 5'd0;
    end
    if (!has_dst) dst = 5'd0;
  end

  assign wen = has_dst && (dst != 5'd0);

  always_comb begin
    need_rs = 1'b1;
    need_rt = 1'b0;
    if (op == OP_SPECIAL) begin
      need_rs = !is_shift;
      need_rt = 1'b1;
    end else if (op == OP_BEQ || op == OP_BNE || is_store(op)) begin
      need_rt = 1'b1;
    end else if (op == OP_LUI || op == OP_J || op == OP_JAL || op == OP_BC) begin
      need_rs = 1'b0;
    end
  end

  always_comb begin
    imm = {{16{imm16[15]}}, imm16};
    if (op == OP_ANDI || op == OP_ORI || op == OP_XORI)
      imm = {16'h0, imm16};
    else if (op == OP_LUI)
      imm = {imm16, 16'h0};
    else if (op == OP_J || op == OP_JAL)
      imm = {cur_pc[31:28], cur_cmd[25:0], 2'b00};
    else if (op == OP_BC)
      imm = {{4{cur_cmd[25]}}, cur_cmd[25:0], 2'b00};
  end

  assign rs_addr = rs;
  assign rt_addr = rt;

  decode_scoreboard u_sb (
    .clk        (clk),
    .rstn       (rstn),
    .set_en_i   (issue && wen),
    .set_reg_i  (dst),
    .clr_en_i   (wb_en),
    .clr_reg_i  (wb_reg),
    .qa_addr_i  (rs),
    .qb_addr_i  (rt),
    .qa_ready_o (rs_rdy),
    .qb_ready_o (rt_rdy)
  );

  assign ready = (!need_rs || rs_rdy) && (!need_rt || rt_rdy);

  always_comb begin
    state_d    = state_q;
    hold_pc_d  = hold_pc_q;
    hold_cmd_d = hold_cmd_q;
    issue      = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          if (ready) begin
            issue = 1'b1;
          end else begin
            state_d    = HOLD;
            hold_pc_d  = pc;
            hold_cmd_d = command;
          end
        end
      end
      HOLD: begin
        if (ready) begin
          issue   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // redirect kills both the held and the incoming instruction
    if (flush) begin
      issue   = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      hold_pc_q  <= '0;
      hold_cmd_q <= '0;
      done_q     <= 1'b0;
      d_pc_q     <= '0;
      d_cmd_q    <= '0;
      d_imm_q    <= '0;
      d_rs_q     <= '0;
      d_rt_q     <= '0;
      d_dst_q    <= '0;
      d_wen_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_pc_q  <= hold_pc_d;
      hold_cmd_q <= hold_cmd_d;
      done_q     <= issue;
      if (issue) begin
        d_pc_q  <= cur_pc;
        d_cmd_q <= cur_cmd;
        d_imm_q <= imm;
        d_rs_q  <= rs_data;
        d_rt_q  <= rt_data;
        d_dst_q <= dst;
        d_wen_q <= wen;
      end
    end
  end

  assign stall     = (state_q == HOLD);
  assign done      = done_q;
  assign d_pc      = d_pc_q;
  assign d_command = d_cmd_q;
  assign d_imm     = d_imm_q;
  assign d_rs_val  = d_rs_q;
  assign d_rt_val  = d_rt_q;
  assign d_dst     = d_dst_q;
  assign d_wen     = d_wen_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected bundles queued at drive time,
// popped and compared when done is observed.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rstn, enable, flush, wb_en;
  logic [31:0] pc, command;
  logic [4:0]  wb_reg;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data;
  logic        stall, done, d_wen;
  logic [31:0] d_pc, d_command, d_imm, d_rs_val, d_rt_val;
  logic [4:0]  d_dst;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] pc, cmd, imm, rsv, rtv;
    logic [4:0]  dst;
    logic        wen;
    bit          chk_dst;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  // register file stand-in: value encodes the address read
  assign rs_data = 32'hA000_0000 | {27'd0, rs_addr};
  assign rt_data = 32'hB000_0000 | {27'd0, rt_addr};

  decode_stage dut (
    .clk(clk), .rstn(rstn), .enable(enable), .pc(pc), .command(command),
    .flush(flush), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .wb_en(wb_en), .wb_reg(wb_reg),
    .stall(stall), .done(done), .d_pc(d_pc), .d_command(d_command),
    .d_imm(d_imm), .d_rs_val(d_rs_val), .d_rt_val(d_rt_val),
    .d_dst(d_dst), .d_wen(d_wen)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] c, input logic [31:0] im,
                      input logic [31:0] rsv, input logic [31:0] rtv,
                      input logic [4:0] dst, input logic wen, input bit chk_dst);
    exp_t e;
    e.pc = p; e.cmd = c; e.imm = im; e.rsv = rsv; e.rtv = rtv;
    e.dst = dst; e.wen = wen; e.chk_dst = chk_dst;
    q.push_back(e);
  endtask

  task automatic send(input logic [31:0] p, input logic [31:0] c);
    enable = 1'b1; pc = p; command = c;
    cyc();
    enable = 1'b0;
  endtask

  task automatic check_issue(input string tag);
    exp_t e;
    chk({tag, ".done"}, done, 1);
    chk({tag, ".stall"}, stall, 0);
    chk({tag, ".queued"}, q.size() != 0, 1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({tag, ".pc"},  d_pc, e.pc);
      chk({tag, ".cmd"}, d_command, e.cmd);
      chk({tag, ".imm"}, d_imm, e.imm);
      chk({tag, ".rs"},  d_rs_val, e.rsv);
      chk({tag, ".rt"},  d_rt_val, e.rtv);
      chk({tag, ".wen"}, d_wen, e.wen);
      if (e.chk_dst) chk({tag, ".dst"}, d_dst, e.dst);
    end
  endtask

  task automatic check_quiet(input string tag, input logic exp_stall);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".stall"}, stall, exp_stall);
  endtask

  task automatic writeback(input logic [4:0] r);
    wb_en = 1'b1; wb_reg = r;
    cyc();
    wb_en = 1'b0; wb_reg = 5'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; enable = 1'b0; flush = 1'b0; wb_en = 1'b0;
    wb_reg = 5'd0; pc = '0; command = '0;
    repeat (3) cyc();
    rstn = 1'b1;
    cyc();
    check_quiet("reset", 1'b0);
    chk("reset.d_pc", d_pc, 0);
    chk("reset.d_imm", d_imm, 0);
    chk("reset.d_dst", d_dst, 0);
    chk("reset.d_wen", d_wen, 0);
    chk("reset.busy", dut.u_sb.busy_q, 0);

    // ADDI r5,r0,7
    push(32'h100, 32'h2005_0007, 32'h7, 32'hA000_0000, 32'hB000_0005, 5'd5, 1'b1, 1);
    send(32'h100, 32'h2005_0007);
    check_issue("addi");
    cyc();
    check_quiet("addi.single", 1'b0);
    chk("addi.busy5", dut.u_sb.busy_q[5], 1);

    // ORI zero-extends, ADDI sign-extends
    push(32'h104, 32'h3403_8000, 32'h0000_8000, 32'hA000_0000, 32'hB000_0003, 5'd3, 1'b1, 1);
    send(32'h104, 32'h3403_8000);
    check_issue("ori");
    push(32'h108, 32'h2003_8000, 32'hFFFF_8000, 32'hA000_0000, 32'hB000_0003, 5'd3, 1'b1, 1);
    send(32'h108, 32'h2003_8000);
    check_issue("addi_neg");

    // ADD r6,r5,r5 blocked on r5, released by write-back three cycles later
    send(32'h200, 32'h00A5_3020);
    check_quiet("add.hold0", 1'b1);
    chk("add.rs_addr", rs_addr, 5);
    cyc(); check_quiet("add.hold1", 1'b1);
    cyc(); check_quiet("add.hold2", 1'b1);
    push(32'h200, 32'h00A5_3020, 32'h0000_3020, 32'hA000_0005, 32'hB000_0005, 5'd6, 1'b1, 1);
    writeback(5'd5);
    check_issue("add");
    chk("add.busy6", dut.u_sb.busy_q[6], 1);
    chk("add.busy5", dut.u_sb.busy_q[5], 0);
    cyc();
    check_quiet("add.after", 1'b0);

    // ADD r7,r6,r0 blocked, then flushed
    send(32'h204, 32'h00C0_3820);
    check_quiet("flush.hold", 1'b1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check_quiet("flush.kill", 1'b0);
    cyc();
    check_quiet("flush.after", 1'b0);
    chk("flush.busy6", dut.u_sb.busy_q[6], 1);
    push(32'h208, 32'h2008_0010, 32'h10, 32'hA000_0000, 32'hB000_0008, 5'd8, 1'b1, 1);
    send(32'h208, 32'h2008_0010);
    check_issue("post_flush");

    // JAL then JR r31
    push(32'h1000_0000, 32'h0C00_0040, 32'h1000_0100, 32'hA000_0000, 32'hB000_0000, 5'd31, 1'b1, 1);
    send(32'h1000_0000, 32'h0C00_0040);
    check_issue("jal");
    writeback(5'd31);
    push(32'h1000_0004, 32'h03E0_0009, 32'h9, 32'hA000_001F, 32'hB000_0000, 5'd0, 1'b0, 0);
    send(32'h1000_0004, 32'h03E0_0009);
    check_issue("jr");

    // BEQ blocked via rt (r6), then via rs (r8)
    send(32'h300, 32'h1006_FFFC);
    check_quiet("beq_rt.hold", 1'b1);
    chk("beq_rt.rt_addr", rt_addr, 6);
    push(32'h300, 32'h1006_FFFC, 32'hFFFF_FFFC, 32'hA000_0000, 32'hB000_0006, 5'd0, 1'b0, 0);
    writeback(5'd6);
    check_issue("beq_rt");
    send(32'h304, 32'h1100_0010);
    check_quiet("beq_rs.hold", 1'b1);
    push(32'h304, 32'h1100_0010, 32'h10, 32'hA000_0008, 32'hB000_0000, 5'd0, 1'b0, 0);
    writeback(5'd8);
    check_issue("beq_rs");

    // LUI
    push(32'h400, 32'h3C09_1234, 32'h1234_0000, 32'hA000_0000, 32'hB000_0009, 5'd9, 1'b1, 1);
    send(32'h400, 32'h3C09_1234);
    check_issue("lui");

    // mark every register busy with ADDI ri,r0,i
    for (int i = 1; i < 32; i++) begin
      logic [31:0] c;
      c = 32'h2000_0000 | (i << 16) | i;
      push(32'h1000 + 4 * i, c, i, 32'hA000_0000, 32'hB000_0000 | i, i[4:0], 1'b1, 1);
      send(32'h1000 + 4 * i, c);
      check_issue("fill");
    end
    chk("fill.busy", dut.u_sb.busy_q, 32'hFFFF_FFFE);

    // NOP never stalls
    push(32'h500, 32'h0, 32'h0, 32'hA000_0000, 32'hB000_0000, 5'd0, 1'b0, 0);
    send(32'h500, 32'h0);
    check_issue("nop");

    // reset during HOLD
    send(32'h600, 32'h00A5_3020);
    check_quiet("rst.hold", 1'b1);
    rstn = 1'b0;
    cyc();
    check_quiet("rst.in", 1'b0);
    chk("rst.d_pc", d_pc, 0);
    chk("rst.d_command", d_command, 0);
    chk("rst.d_imm", d_imm, 0);
    chk("rst.d_rs", d_rs_val, 0);
    chk("rst.d_rt", d_rt_val, 0);
    chk("rst.d_dst", d_dst, 0);
    chk("rst.d_wen", d_wen, 0);
    chk("rst.busy", dut.u_sb.busy_q, 0);
    rstn = 1'b1;
    cyc();
    check_quiet("rst.out0", 1'b0);
    cyc();
    check_quiet("rst.out1", 1'b0);
    chk("queue.empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Second pipeline stage of the core, directly downstream of instruction fetch. Each instruction arrives with the fetch `done` pulse; the stage splits it into fields, reads the register file and extends the immediate. A 32-entry busy scoreboard holds back any instruction whose sources are still pending write-back. Output is a registered decode bundle with a one-cycle `done` pulse for the execute stage.

## Interface
Parameters:
- none; all widths fixed by the 32-bit MIPS-like ISA.

Ports:
- `clk`  in  1  clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `enable`  in  1  fetch `done`; `pc`/`command` valid this posedge.
- `pc`  in  32  address of `command`.
- `command`  in  32  instruction word.
- `flush`  in  1  execute redirect (same signal as fetch `pcenable`); kill held/incoming instruction.
- `rs_addr`, `rt_addr`  out  5 each  register-file read addresses (combinational from the current instruction).
- `rs_data`, `rt_data`  in  32 each  register-file read data (write-first).
- `wb_en`  in  1  write-back strobe.
- `wb_reg`  in  5  write-back destination; clears its busy bit.
- `stall`  out  1  instruction held for a hazard; fetch must not be enabled.
- `done`  out  1  one-cycle pulse, bundle valid.
- `d_pc`  out  32,  `d_command`  out  32,  `d_imm`  out  32,  `d_rs_val`/`d_rt_val`  out  32 each,  `d_dst`  out  5,  `d_wen`  out  1.

## Operation
- Fields: op=cmd[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0].
- Destination:
  - op 000000: rd, except funct 001001 with rd=0 (JR), which has no destination.
  - JAL (000011): 31.
  - J, BC (110010), BEQ/BNE (00010x), stores (op[5:3]=101): no destination.
  - Other I-type: rt.
  - `d_wen` = destination present and destination ≠ 0.
- Sources:
  - R-type reads rs and rt; shifts SLL/SRL/SRA (funct 000000/000010/000011) read rt only.
  - Branches and stores read rs and rt.
  - LUI, J, JAL and BC read nothing.
  - Other I-type reads rs.
  - Register 0 is never a hazard.
- Immediate:
  - ANDI/ORI/XORI (0011xx except LUI): zero-extend.
  - LUI (001111): {imm16, 16'h0}.
  - J/JAL: {pc[31:28], cmd[25:0], 2'b00}.
  - BC: sign-extended {cmd[25:0], 2'b00}.
  - Otherwise: sign-extended imm16.
- Scoreboard:
  - 32-bit `busy` mask. A source is ready if its busy bit is clear, or if `wb_en && wb_reg` names it this cycle (bypass through the write-first register file).
- FSM:
  - IDLE: on `enable`, if all sources are ready, issue. Otherwise latch `pc`/`command` into a hold register, go to HOLD, `stall`=1.
  - HOLD: re-check every cycle against the held instruction. When ready, issue, clear `stall`, return to IDLE.
- Issue: register all `d_*` outputs, pulse `done`, set `busy[d_dst]` when `d_wen`=1.
- `flush` has priority over issue. No `done`; state goes to IDLE; `stall`=0; held instruction discarded. `busy` is unchanged, because issued instructions are older than the redirect.
- `enable` while in HOLD cannot happen by protocol; if it occurs, it is ignored.

## Timing
- Reset values: `busy`=0, state IDLE, `done`=0, `stall`=0, every `d_*`=0.
- Latency: `enable` at edge N with no hazard gives `done`=1 after edge N+1.
- `stall` rises after the edge that sampled the blocked instruction. Once the write-back that unblocks it is seen at edge M, `done` is high and `stall` low after edge M+1.
- Same-cycle write-back clear and issue set on one register: the set wins.
- `done` is never high for two consecutive cycles without a fresh `enable` or a HOLD release.
- Reset mid-HOLD: state IDLE, `busy` cleared, no `done`.

## Structure
- Package `decode_pkg` holds:
  - opcode constants: OP_SPECIAL, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BC, OP_LUI, OP_ANDI, OP_ORI, OP_XORI;
  - funct constants: FN_JR, FN_SLL, FN_SRL, FN_SRA;
  - state enum {IDLE, HOLD}.
- Sub-module `decode_scoreboard` owns the busy mask. Inputs: set port (reg, en), clear port (reg, en), two query addresses. Outputs: ready bits.
- Field/immediate/destination logic is combinational in the top level.

## Test plan
- ADDI r5,r0,7 (0x20050007) with `enable` and `busy`=0 → `done` next cycle; `d_imm`=7, `d_dst`=5, `d_wen`=1; `busy[5]`=1.
- ORI r3,r0,0x8000 → `d_imm`=0x00008000. ADDI r3,r0,0x8000 → `d_imm`=0xFFFF8000.
- ADD r6,r5,r5 while `busy[5]`=1 → `stall`=1, no `done`; `wb_en`/`wb_reg`=5 three cycles later → `done` on the next cycle, `busy[6]`=1, `busy[5]`=0.
- `flush` while in HOLD → `stall`=0, no `done`, state IDLE; a following independent instruction issues normally.
- JAL 0x0000040 at `pc`=0x10000000 → `d_imm`=0x10000100, `d_dst`=31. JR r31 → `d_wen`=0. BEQ → `d_wen`=0 and both sources checked.
- `command`=0 (NOP) → `d_wen`=0, no stall even with `busy`=all-ones. `rstn` low during HOLD → all outputs 0, `busy`=0.
